// File: rtl/core_pkg.sv
// Shared core definitions: loader state encoding and bus constants.
// Used by imem_loader and the core top level.
package core_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_REQ  = 2'd1,
        LDR_DATA = 2'd2,
        LDR_DONE = 2'd3
    } ldr_state_t;

    localparam int AVM_BURST_WIDTH = 12;

    localparam logic [3:0] IMEM_BE_ALL = 4'hF;

endpackage

// File: rtl/imem_loader.sv
// Burst-reads a program image over Avalon-MM into imem while holding the core.
// Define IMEM_LOADER_CHECKSUM_EN to add the running checksum output.
module imem_loader
    import core_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 12,
    parameter int MAX_BURST       = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                src_addr,
    input  logic [IMEM_ADDR_WIDTH:0]   num_words,
    output logic                       busy,
    output logic                       done,
    output logic                       core_hold,
    input  logic                       avm_rx_waitrequest,
    output logic [AVM_BURST_WIDTH-1:0] avm_rx_burstcount,
    output logic [31:0]                avm_rx_address,
    output logic                       avm_rx_read,
    input  logic [31:0]                avm_rx_readdata,
    input  logic                       avm_rx_readdatavalid,
    output logic                       imem_write,
    output logic [31:0]                imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic [3:0]                 imem_be
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                checksum
`endif
);

    localparam int CW = IMEM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};

    ldr_state_t                 state;
    logic [31:0]                rd_addr;
    logic [CW-1:0]              remaining;
    logic [CW-1:0]              wr_idx;
    logic [CW-1:0]              clamped;
    logic [AVM_BURST_WIDTH-1:0] beats;
    logic                       last_beat;

    function automatic logic [AVM_BURST_WIDTH-1:0] burst_len(
        input logic [CW-1:0] rem
    );
        if (int'(rem) > MAX_BURST) begin
            return AVM_BURST_WIDTH'(MAX_BURST);
        end
        return AVM_BURST_WIDTH'(rem);
    endfunction

    assign clamped   = (num_words > DEPTH) ? DEPTH : num_words;
    assign last_beat = (beats == AVM_BURST_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= LDR_IDLE;
            rd_addr           <= '0;
            remaining         <= '0;
            wr_idx            <= '0;
            beats             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            core_hold         <= 1'b0;
            avm_rx_read       <= 1'b0;
            avm_rx_address    <= '0;
            avm_rx_burstcount <= '0;
            imem_write        <= 1'b0;
            imem_waddr        <= '0;
            imem_wdata        <= '0;
            imem_be           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum          <= '0;
`endif
        end else begin
            imem_write <= 1'b0;
            imem_be    <= '0;
            done       <= 1'b0;
            unique case (state)
                LDR_IDLE: begin
                    if (start) begin
                        rd_addr   <= src_addr & ~32'h3;
                        remaining <= clamped;
                        wr_idx    <= '0;
                        busy      <= 1'b1;
                        core_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (clamped == '0) begin
                            state <= LDR_DONE;
                        end else begin
                            state             <= LDR_REQ;
                            avm_rx_read       <= 1'b1;
                            avm_rx_address    <= src_addr & ~32'h3;
                            avm_rx_burstcount <= burst_len(clamped);
                        end
                    end
                end
                LDR_REQ: begin
                    // Address and count stay registered until the slave accepts.
                    if (!avm_rx_waitrequest) begin
                        avm_rx_read <= 1'b0;
                        beats       <= avm_rx_burstcount;
                        remaining   <= remaining - CW'(avm_rx_burstcount);
                        rd_addr     <= rd_addr + (32'(avm_rx_burstcount) << 2);
                        state       <= LDR_DATA;
                    end
                end
                LDR_DATA: begin
                    if (avm_rx_readdatavalid) begin
                        imem_write <= 1'b1;
                        imem_be    <= IMEM_BE_ALL;
                        imem_waddr <= 32'({wr_idx, 2'b00});
                        imem_wdata <= avm_rx_readdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum   <= checksum + avm_rx_readdata;
`endif
                        wr_idx     <= wr_idx + CW'(1);
                        beats      <= beats - AVM_BURST_WIDTH'(1);
                        if (last_beat) begin
                            if (remaining != '0) begin
                                state             <= LDR_REQ;
                                avm_rx_read       <= 1'b1;
                                avm_rx_address    <= rd_addr;
                                avm_rx_burstcount <= burst_len(remaining);
                            end else begin
                                state <= LDR_DONE;
                            end
                        end
                    end
                end
                LDR_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    core_hold <= 1'b0;
                    state     <= LDR_IDLE;
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an Avalon slave and an image model.
// Checks the checksum output too when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int LAT = 3;
    localparam int MAXB = 64;
    localparam int DEPTH = 4096;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          cnt;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [12:0] num_words;
    logic        busy;
    logic        done;
    logic        core_hold;
    logic        avm_rx_waitrequest = 1'b0;
    logic [11:0] avm_rx_burstcount;
    logic [31:0] avm_rx_address;
    logic        avm_rx_read;
    logic [31:0] avm_rx_readdata = 32'h0;
    logic        avm_rx_readdatavalid = 1'b0;
    logic        imem_write;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_be;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    imem_loader #(
        .IMEM_ADDR_WIDTH(12),
        .MAX_BURST(MAXB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_addr(src_addr),
        .num_words(num_words),
        .busy(busy),
        .done(done),
        .core_hold(core_hold),
        .avm_rx_waitrequest(avm_rx_waitrequest),
        .avm_rx_burstcount(avm_rx_burstcount),
        .avm_rx_address(avm_rx_address),
        .avm_rx_read(avm_rx_read),
        .avm_rx_readdata(avm_rx_readdata),
        .avm_rx_readdatavalid(avm_rx_readdatavalid),
        .imem_write(imem_write),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .imem_be(imem_be)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    beat_t       beatq[$];
    req_t        exp_req[$];
    req_t        obs_req[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_sum;
    int          data_mode;
    int          seq;
    int          stall_left;
    int          stall_seen;
    int          wr_seen;
    int          acc_cnt;
    int          done_seen;
    int          last_wr_cyc;
    int          next_free;
    logic [31:0] last_waddr;
    logic        stalled_prev;
    logic [31:0] saved_addr;
    logic [11:0] saved_bc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Image model: word i of the image lands at byte i*4; bursts split at MAXB.
    task automatic build_model(input logic [31:0] src, input int n);
        int          rem;
        logic [31:0] a;
        int          b;
        wr_t         w;
        req_t        r;
        rem = (n > DEPTH) ? DEPTH : n;
        a = src & ~32'h3;
        exp_wr.delete();
        exp_req.delete();
        exp_sum = 32'h0;
        for (int i = 0; i < rem; i++) begin
            w.addr = 32'(i * 4);
            w.data = (data_mode == 1) ? 32'(i + 1) : a + 32'(i * 4);
            exp_sum += w.data;
            exp_wr.push_back(w);
        end
        while (rem > 0) begin
            b = (rem > MAXB) ? MAXB : rem;
            r.addr = a;
            r.cnt = b;
            exp_req.push_back(r);
            a += 32'(b * 4);
            rem -= b;
        end
    endtask

    // Slave plus output monitor, all at the falling edge.
    initial begin
        beat_t b;
        req_t  r;
        wr_t   w;
        stalled_prev = 1'b0;
        next_free = 0;
        forever begin
            @(negedge clk);
            if (imem_write) begin
                wr_seen++;
                last_wr_cyc = cyc;
                last_waddr = imem_waddr;
                if (exp_wr.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    w = exp_wr.pop_front();
                    check("imem_waddr", imem_waddr, w.addr);
                    check("imem_wdata", imem_wdata, w.data);
                end
                check("imem_be", 32'(imem_be), 32'hF);
            end
            if (done) begin
                done_seen++;
                check("done_busy_low", 32'(busy), 32'h0);
                check("done_hold_low", 32'(core_hold), 32'h0);
                if (wr_seen > 0)
                    check("done_after_write", 32'(cyc), 32'(last_wr_cyc + 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
                check("checksum_model", checksum, exp_sum);
`endif
            end
            if (stalled_prev) begin
                check("stall_read", 32'(avm_rx_read), 32'h1);
                check("stall_addr", avm_rx_address, saved_addr);
                check("stall_bc", 32'(avm_rx_burstcount), 32'(saved_bc));
            end
            if (beatq.size() > 0 && beatq[0].cyc <= cyc) begin
                b = beatq.pop_front();
                avm_rx_readdatavalid = 1'b1;
                avm_rx_readdata = b.data;
            end else begin
                avm_rx_readdatavalid = 1'b0;
                avm_rx_readdata = 32'hDEAD_BEEF;
            end
            avm_rx_waitrequest = avm_rx_read && (stall_left > 0);
            stalled_prev = avm_rx_waitrequest;
            saved_addr = avm_rx_address;
            saved_bc = avm_rx_burstcount;
            if (avm_rx_waitrequest) begin
                stall_left--;
                stall_seen++;
            end
            if (avm_rx_read && !avm_rx_waitrequest) begin
                acc_cnt++;
                r.addr = avm_rx_address;
                r.cnt = int'(avm_rx_burstcount);
                obs_req.push_back(r);
                if (exp_req.size() == 0) begin
                    flag("unexpected_request");
                end else begin
                    r = exp_req.pop_front();
                    check("req_addr", avm_rx_address, r.addr);
                    check("req_count", 32'(avm_rx_burstcount), 32'(r.cnt));
                end
                if (next_free < cyc + LAT) next_free = cyc + LAT;
                for (int j = 0; j < int'(avm_rx_burstcount); j++) begin
                    b.cyc = next_free + j;
                    if (data_mode == 1) begin
                        seq++;
                        b.data = 32'(seq);
                    end else begin
                        b.data = avm_rx_address + 32'(j * 4);
                    end
                    beatq.push_back(b);
                end
                next_free += int'(avm_rx_burstcount);
            end
        end
    end

    task automatic check_zero(input string p);
        check({p, "_busy"}, 32'(busy), 32'h0);
        check({p, "_done"}, 32'(done), 32'h0);
        check({p, "_hold"}, 32'(core_hold), 32'h0);
        check({p, "_read"}, 32'(avm_rx_read), 32'h0);
        check({p, "_bc"}, 32'(avm_rx_burstcount), 32'h0);
        check({p, "_addr"}, avm_rx_address, 32'h0);
        check({p, "_write"}, 32'(imem_write), 32'h0);
        check({p, "_waddr"}, imem_waddr, 32'h0);
        check({p, "_wdata"}, imem_wdata, 32'h0);
        check({p, "_be"}, 32'(imem_be), 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({p, "_checksum"}, checksum, 32'h0);
`endif
    endtask

    task automatic begin_load(input logic [31:0] src, input int n,
                              input int stall, input int mode);
        data_mode = mode;
        seq = 0;
        stall_left = stall;
        stall_seen = 0;
        build_model(src, n);
        obs_req.delete();
        wr_seen = 0;
        acc_cnt = 0;
        done_seen = 0;
        src_addr = src;
        num_words = 13'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_hold", 32'(core_hold), 32'h1);
        check("t1_read", 32'(avm_rx_read), (n > 0) ? 32'h1 : 32'h0);
    endtask

    task automatic run_load(input logic [31:0] src, input int n,
                            input int stall, input int mode);
        int t;
        begin_load(src, n, stall, mode);
        if (n == 0) begin
            @(negedge clk);
            check("zero_done_t2", 32'(done), 32'h1);
        end else begin
            t = 0;
            while (done_seen == 0 && t < 8000) begin
                @(negedge clk);
                t++;
            end
            if (done_seen == 0) flag("done_timeout");
        end
        repeat (3) @(negedge clk);
        check("req_left", 32'(exp_req.size()), 32'h0);
        check("wr_left", 32'(exp_wr.size()), 32'h0);
        check("done_count", 32'(done_seen), 32'h1);
    endtask

    initial begin
        int k;
        int t;
        reset = 1'b1;
        start = 1'b0;
        src_addr = 32'h0;
        num_words = 13'h0;
        data_mode = 0;
        stall_left = 0;
        wr_seen = 0;
        done_seen = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_load(32'h1000, 16, 0, 0);
        check("single_bursts", 32'(acc_cnt), 32'd1);
        check("single_writes", 32'(wr_seen), 32'd16);
        check("single_last_waddr", last_waddr, 32'h3C);

        run_load(32'h0, 150, 0, 0);
        check("multi_bursts", 32'(acc_cnt), 32'd3);
        if (obs_req.size() == 3) begin
            check("multi_b1_addr", obs_req[1].addr, 32'h100);
            check("multi_b1_cnt", 32'(obs_req[1].cnt), 32'd64);
            check("multi_b2_addr", obs_req[2].addr, 32'h200);
            check("multi_b2_cnt", 32'(obs_req[2].cnt), 32'd22);
        end
        check("multi_last_waddr", last_waddr, 32'h254);

        run_load(32'h4003, 20, 5, 0);
        check("stall_accepts", 32'(acc_cnt), 32'd1);
        check("stall_cycles", 32'(stall_seen), 32'd5);
        if (obs_req.size() == 1)
            check("stall_addr_aligned", obs_req[0].addr, 32'h4000);

        run_load(32'h5000, 0, 0, 0);
        check("zero_accepts", 32'(acc_cnt), 32'd0);
        check("zero_writes", 32'(wr_seen), 32'd0);

        run_load(32'h0, 5000, 0, 0);
        check("clamp_writes", 32'(wr_seen), 32'd4096);
        check("clamp_bursts", 32'(acc_cnt), 32'd64);
        check("clamp_last_waddr", last_waddr, 32'h3FFC);

        begin_load(32'h2000, 16, 0, 0);
        k = 0;
        t = 0;
        while (k < 7 && t < 200) begin
            @(negedge clk);
            t++;
            if (imem_write) k++;
        end
        if (k < 7) flag("midrst_timeout");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("midrst");
        check("midrst_pending", 32'(exp_wr.size()), 32'd9);
        exp_wr.delete();
        exp_req.delete();
        t = 0;
        while (beatq.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("midrst_writes", 32'(wr_seen), 32'd7);
        check("midrst_no_done", 32'(done_seen), 32'd0);

        run_load(32'h3000, 8, 0, 0);
        check("after_rst_writes", 32'(wr_seen), 32'd8);

        run_load(32'h6000, 10, 0, 1);
        check("sum_writes", 32'(wr_seen), 32'd10);
        check("sum_model", exp_sum, 32'd55);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("checksum_55", checksum, 32'd55);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
